multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock; Reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: op  in  6  instruction opcode; zero  in  1  ALU result==0; sign  in  1  ALU result[31].
REQ-003 SHALL have 1-bit outputs: PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc.
REQ-004 SHALL have outputs: RegDst  2  (00 $31, 01 rt, 10 rd); ExtSel  2  (00 sa zero-ext, 01 imm zero-ext, 10 imm sign-ext); PCSrc  2  (00 PC+4, 01 branch target, 10 rs, 11 jump addr); ALUOp  3; state  3  current state.

Function
REQ-005 SHALL decode opcodes: add 000000, sub 000001, addiu 000010, and 010001, andi 010000, or 010011, ori 010010, sll 011000, slt 100111, slti 100110, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
REQ-006 SHALL implement a Moore/Mealy FSM with encodings: sIF 000, sID 001, sEXE_LS 010, sMEM 011, sWB_LD 100, sEXE_BR 101, sEXE_AL 110, sWB_AL 111.
REQ-007 SHALL transition: sIF->sID; sID->sIF for j/jal/jr; sID->sEXE_BR for beq/bne/bltz; sID->sEXE_LS for sw/lw; sID->sID for halt; sID->sEXE_AL for all others.
REQ-008 SHALL transition: sEXE_AL->sWB_AL->sIF; sEXE_BR->sIF; sEXE_LS->sMEM; sMEM->sIF for sw, sMEM->sWB_LD for lw; sWB_LD->sIF.
REQ-009 SHALL treat undefined opcodes as halt (remain in sID, no writes).
REQ-010 SHALL assert IRWre only in sIF; InsMemRW constant 1.
REQ-011 SHALL assert PCWre exactly one cycle per instruction: sID for j/jal/jr, sEXE_BR, sMEM for sw, sWB_AL, sWB_LD; never for halt.
REQ-012 SHALL assert RegWre only in sWB_AL, sWB_LD, and sID for jal; mWR only in sMEM for sw; mRD only in sMEM for lw.
REQ-013 SHALL drive PCSrc: 11 for j/jal, 10 for jr, 01 for beq with zero=1, bne with zero=0, bltz with sign=1; 00 otherwise.
REQ-014 SHALL drive ExtSel 00 for sll, 01 for andi/ori, 10 for all other opcodes.
REQ-015 SHALL drive ALUSrcA=1 only for sll; ALUSrcB=1 for addiu/andi/ori/slti/sw/lw; DBDataSrc=1 only for lw.
REQ-016 SHALL drive WrRegDSrc=0 only for jal (PC+4 writeback), 1 otherwise; RegDst 00 for jal, 01 for addiu/andi/ori/slti/lw, 10 otherwise.
REQ-017 SHALL drive ALUOp: 000 add (add/addiu/sw/lw), 001 sub (sub/beq/bne/bltz), 010 sll, 011 or/ori, 100 and/andi, 101 slt/slti; 000 for others.
REQ-018 SHALL decode op combinationally from the held IR value; op is stable from sID until next sIF.
REQ-019 SHALL keep all write enables (PCWre, RegWre, mWR, mRD, IRWre) low outside the states listed, regardless of op.

Reset
REQ-020 SHALL force state=sIF asynchronously while Reset=1, and hold it until first rising CLK edge after Reset falls.
REQ-021 SHALL drive during reset: PCWre=0, RegWre=0, mWR=0, mRD=0, IRWre=0, PCSrc=00, other outputs 0 except InsMemRW=1.
REQ-022 SHALL abandon any in-flight instruction on Reset assertion mid-operation, with no partial write after release.

Verification
REQ-023 add (000000): reset, 5 edges -> states 000,001,110,111,000; PCWre=1 and RegWre=1 only in 111, RegDst=10.
REQ-024 lw (110001): states 000,001,010,011,100; mRD=1 in 011, RegWre=1/DBDataSrc=1/PCWre=1 in 100, ExtSel=10.
REQ-025 beq with zero=1 then zero=0: in 101 PCSrc=01 then 00, PCWre=1, RegWre=0.
REQ-026 jal (111010): 000->001->000; in 001 PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1.
REQ-027 halt (111111): state stays 001 for 10 edges, PCWre=0, RegWre=0, mWR=0.
REQ-028 Reset pulse asserted in sMEM for sw between edges -> state 000 immediately, mWR=0, PCWre=0.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Control unit for a multi-cycle MIPS-style CPU. It steps each instruction through fetch/decode/execute/mem/writeback
// and drives the datapath controls from the current state and the held opcode.
module multi_cycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] ExtSel,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  state_t cur;
  logic   is_jump, is_branch, is_sw, is_lw, is_alu;

  // Instruction class; anything unlisted (including halt) falls through as a stall.
  always_comb begin
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_sw     = 1'b0;
    is_lw     = 1'b0;
    is_alu    = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_OR, OP_ORI,
      OP_SLL, OP_SLT, OP_SLTI:   is_alu    = 1'b1;
      OP_SW:                     is_sw     = 1'b1;
      OP_LW:                     is_lw     = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTZ:   is_branch = 1'b1;
      OP_J, OP_JR, OP_JAL:       is_jump   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cur <= S_IF;
    end else begin
      case (cur)
        S_IF:     cur <= S_ID;
        S_ID: begin
          if (is_jump)                cur <= S_IF;
          else if (is_branch)         cur <= S_EXE_BR;
          else if (is_sw || is_lw)    cur <= S_EXE_LS;
          else if (is_alu)            cur <= S_EXE_AL;
          else                        cur <= S_ID;
        end
        S_EXE_AL: cur <= S_WB_AL;
        S_WB_AL:  cur <= S_IF;
        S_EXE_BR: cur <= S_IF;
        S_EXE_LS: cur <= S_MEM;
        S_MEM:    cur <= is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  cur <= S_IF;
        default:  cur <= S_IF;
      endcase
    end
  end

  assign state = 3'(cur);

  // Outputs follow state and opcode within the cycle; everything except InsMemRW is held low in reset.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b1;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst    = 2'b00;
    ExtSel    = 2'b00;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;
    if (!Reset) begin
      ALUSrcA   = (op == OP_SLL);
      ALUSrcB   = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
                  (op == OP_SLTI)  || is_sw || is_lw;
      DBDataSrc = is_lw;
      WrRegDSrc = (op != OP_JAL);
      if (op == OP_JAL)
        RegDst = 2'b00;
      else if ((op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI) || is_lw)
        RegDst = 2'b01;
      else
        RegDst = 2'b10;
      if (op == OP_SLL)                          ExtSel = 2'b00;
      else if ((op == OP_ANDI) || (op == OP_ORI)) ExtSel = 2'b01;
      else                                       ExtSel = 2'b10;
      case (op)
        OP_J, OP_JAL: PCSrc = 2'b11;
        OP_JR:        PCSrc = 2'b10;
        OP_BEQ:       PCSrc = zero  ? 2'b01 : 2'b00;
        OP_BNE:       PCSrc = !zero ? 2'b01 : 2'b00;
        OP_BLTZ:      PCSrc = sign  ? 2'b01 : 2'b00;
        default:      PCSrc = 2'b00;
      endcase
      case (op)
        OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ALUOp = 3'b001;
        OP_SLL:                          ALUOp = 3'b010;
        OP_OR, OP_ORI:                   ALUOp = 3'b011;
        OP_AND, OP_ANDI:                 ALUOp = 3'b100;
        OP_SLT, OP_SLTI:                 ALUOp = 3'b101;
        default:                         ALUOp = 3'b000;
      endcase
      IRWre = (cur == S_IF);
      case (cur)
        S_ID: begin
          PCWre  = is_jump;
          RegWre = (op == OP_JAL);
        end
        S_EXE_BR: PCWre = 1'b1;
        S_MEM: begin
          PCWre = is_sw;
          mWR   = is_sw;
          mRD   = is_lw;
        end
        S_WB_AL, S_WB_LD: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: each instruction is expanded into its list of visited
// states and compared cycle by cycle against controls derived from the opcode table.
module tb_multi_cycle_control;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero, sign;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc;
  logic [1:0] RegDst, ExtSel, PCSrc;
  logic [2:0] ALUOp, state;

  int checks = 0;
  int failures = 0;

  multi_cycle_control dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
    .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .ExtSel(ExtSel), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .state(state)
  );

  always #5 CLK = ~CLK;

  // Instruction kinds: 0 alu, 1 jump, 2 branch, 3 sw, 4 lw, 5 halt/undefined
  typedef struct packed {
    int unsigned kind;
    logic [1:0]  ext;
    logic        a, b, db, wr;
    logic [1:0]  rd;
    logic [2:0]  alu;
  } dec_t;

  logic [5:0] ops [19] = '{6'b000000, 6'b000001, 6'b000010, 6'b010001, 6'b010000,
                           6'b010011, 6'b010010, 6'b011000, 6'b100111, 6'b100110,
                           6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b110110,
                           6'b111000, 6'b111001, 6'b111010, 6'b111111};

  function automatic dec_t decode(input logic [5:0] o);
    //              kind ext  a  b  db wr  rd    alu
    case (o)
      6'b000000: return '{0, 2'd2, 0, 0, 0, 1, 2'd2, 3'd0}; // add
      6'b000001: return '{0, 2'd2, 0, 0, 0, 1, 2'd2, 3'd1}; // sub
      6'b000010: return '{0, 2'd2, 0, 1, 0, 1, 2'd1, 3'd0}; // addiu
      6'b010001: return '{0, 2'd2, 0, 0, 0, 1, 2'd2, 3'd4}; // and
      6'b010000: return '{0, 2'd1, 0, 1, 0, 1, 2'd1, 3'd4}; // andi
      6'b010011: return '{0, 2'd2, 0, 0, 0, 1, 2'd2, 3'd3}; // or
      6'b010010: return '{0, 2'd1, 0, 1, 0, 1, 2'd1, 3'd3}; // ori
      6'b011000: return '{0, 2'd0, 1, 0, 0, 1, 2'd2, 3'd2}; // sll
      6'b100111: return '{0, 2'd2, 0, 0, 0, 1, 2'd2, 3'd5}; // slt
      6'b100110: return '{0, 2'd2, 0, 1, 0, 1, 2'd1, 3'd5}; // slti
      6'b110000: return '{3, 2'd2, 0, 1, 0, 1, 2'd2, 3'd0}; // sw
      6'b110001: return '{4, 2'd2, 0, 1, 1, 1, 2'd1, 3'd0}; // lw
      6'b110100: return '{2, 2'd2, 0, 0, 0, 1, 2'd2, 3'd1}; // beq
      6'b110101: return '{2, 2'd2, 0, 0, 0, 1, 2'd2, 3'd1}; // bne
      6'b110110: return '{2, 2'd2, 0, 0, 0, 1, 2'd2, 3'd1}; // bltz
      6'b111000: return '{1, 2'd2, 0, 0, 0, 1, 2'd2, 3'd0}; // j
      6'b111001: return '{1, 2'd2, 0, 0, 0, 1, 2'd2, 3'd0}; // jr
      6'b111010: return '{1, 2'd2, 0, 0, 0, 0, 2'd0, 3'd0}; // jal
      default:   return '{5, 2'd2, 0, 0, 0, 1, 2'd2, 3'd0}; // halt / undefined
    endcase
  endfunction

  function automatic logic [1:0] exp_pcsrc(input logic [5:0] o, input logic z, input logic s);
    if (o == 6'b111000 || o == 6'b111010) return 2'b11;
    if (o == 6'b111001) return 2'b10;
    if ((o == 6'b110100 && z) || (o == 6'b110101 && !z) || (o == 6'b110110 && s)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] we_word();
    return 32'({PCWre, IRWre, mRD, mWR, RegWre, InsMemRW});
  endfunction

  function automatic logic [31:0] dp_word();
    return 32'({ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, RegDst, ExtSel, PCSrc, ALUOp});
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_we"},    we_word(),  32'b000001);
    check({tag, "_dp"},    dp_word(),  32'd0);
  endtask

  task automatic do_reset();
    #1 Reset = 1'b1;
    #1 check_reset("rst_async");
    @(posedge CLK); #1;
    check_reset("rst_held");
    Reset = 1'b0;
    #1 check("rst_release_state", 32'(state), 32'd0);
  endtask

  // Run one instruction from sIF; rst_step >= 0 aborts with a reset after that step's check.
  task automatic run_instr(input logic [5:0] o, input int rst_step, input int hold, input int zfix);
    dec_t d;
    int unsigned seq[$];
    int n, rs;
    logic last, is_mem;
    logic [31:0] we_exp, dp_exp;
    d = decode(o);
    seq = '{0, 1};
    case (d.kind)
      0: seq = {seq, 6, 7};
      2: seq = {seq, 5};
      3: seq = {seq, 2, 3};
      4: seq = {seq, 2, 3, 4};
      5: for (int i = 1; i < hold; i++) seq.push_back(1);
      default: ;
    endcase
    n  = seq.size();
    rs = (d.kind == 5 && rst_step < 0) ? n - 1 : rst_step;
    op = o;
    for (int s = 0; s < n; s++) begin
      zero = (zfix < 0) ? 1'($urandom) : 1'(zfix);
      sign = 1'($urandom);
      #1;
      last   = (s == n - 1) && (d.kind != 5);
      is_mem = (seq[s] == 3);
      we_exp = 32'({last,
                    s == 0,
                    is_mem && d.kind == 4,
                    is_mem && d.kind == 3,
                    last && (d.kind == 0 || d.kind == 4 || o == 6'b111010),
                    1'b1});
      dp_exp = 32'({d.a, d.b, d.db, d.wr, d.rd, d.ext, exp_pcsrc(o, zero, sign), d.alu});
      check("state", 32'(state), 32'(seq[s]));
      check("we", we_word(), we_exp);
      check("dp", dp_word(), dp_exp);
      if (s == rs) begin
        do_reset();
        return;
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    Reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;
    sign  = 1'b0;
    #2 check_reset("por");
    @(posedge CLK); #1;
    check_reset("por_edge");
    Reset = 1'b0;
    #1 check("por_release", 32'(state), 32'd0);

    run_instr(6'b000000, -1, 0, -1);  // add
    run_instr(6'b110001, -1, 0, -1);  // lw
    run_instr(6'b110100, -1, 0, 1);   // beq taken
    run_instr(6'b110100, -1, 0, 0);   // beq not taken
    run_instr(6'b111010, -1, 0, -1);  // jal
    run_instr(6'b111111, -1, 11, -1); // halt: ten edges held in sID
    run_instr(6'b110000, 3, 0, -1);   // sw aborted in sMEM
    run_instr(6'b101010, -1, 4, -1);  // undefined opcode stalls

    for (int i = 0; i < 300; i++) begin
      logic [5:0] o;
      int rst_at;
      o = ($urandom_range(9) == 0) ? 6'($urandom) : ops[$urandom_range(18)];
      rst_at = ($urandom_range(11) == 0) ? int'($urandom_range(4)) : -1;
      run_instr(o, rst_at, int'($urandom_range(10, 2)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
